// File: rtl/axis_user_check.sv
// AXI-Stream pass-through with a 2-entry skid buffer that strips s_tuser and
// checks it as a modulo beat counter, keeping sticky/saturating error statistics.
module axis_user_check #(
    parameter int DATA_WIDTH  = 8,
    parameter int USER_WIDTH  = 8,
    parameter int ERROR_WIDTH = 16
) (
    input  logic                   clock,
    (* X_INTERFACE_PARAMETER = "POLARITY ACTIVE_HIGH" *)
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic [USER_WIDTH-1:0]  s_tuser,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    input  logic                   clear,
    output logic                   locked,
    output logic                   error_flag,
    output logic [ERROR_WIDTH-1:0] error_count
);

    logic [1:0]             r_count;
    logic                   r_s_tready;
    logic                   r_m_tvalid;
    logic [DATA_WIDTH-1:0]  r_data0;
    logic [DATA_WIDTH-1:0]  r_data1;
    logic                   r_locked;
    logic [USER_WIDTH-1:0]  r_exp;
    logic                   r_err_flag;
    logic [ERROR_WIDTH-1:0] r_err_count;

    logic                   w_acc;
    logic                   w_xfer;
    logic [1:0]             w_count_nxt;
    logic                   w_err;

    assign w_acc       = s_tvalid && r_s_tready;
    assign w_xfer      = r_m_tvalid && m_tready;
    assign w_count_nxt = r_count + 2'(w_acc) - 2'(w_xfer);
    assign w_err       = w_acc && r_locked && (s_tuser != r_exp);

    // Handshake flags are derived from the next occupancy, so both stay
    // registered and m_tready never reaches s_tready combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= 2'd0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_s_tready <= (w_count_nxt != 2'd2);
            r_m_tvalid <= (w_count_nxt != 2'd0);
        end
    end

    // r_data0 is always the head; r_data1 only holds the skid entry.
    always_ff @(posedge clock) begin
        case (r_count)
            2'd0: begin
                if (w_acc) r_data0 <= s_tdata;
            end
            2'd1: begin
                if (w_acc && w_xfer) r_data0 <= s_tdata;
                else if (w_acc)      r_data1 <= s_tdata;
            end
            default: begin
                if (w_xfer) r_data0 <= r_data1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_locked <= 1'b0;
            r_exp    <= '0;
        end else if (w_acc) begin
            r_locked <= 1'b1;
            // Lock, match and resync all land on the same next tag.
            r_exp    <= s_tuser + USER_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_flag  <= 1'b0;
            r_err_count <= '0;
        end else if (clear) begin
            r_err_flag  <= w_err;
            r_err_count <= ERROR_WIDTH'(w_err);
        end else if (w_err) begin
            r_err_flag <= 1'b1;
            if (!(&r_err_count)) r_err_count <= r_err_count + ERROR_WIDTH'(1);
        end
    end

    assign s_tready    = r_s_tready;
    assign m_tvalid    = r_m_tvalid;
    assign m_tdata     = r_data0;
    assign locked      = r_locked;
    assign error_flag  = r_err_flag;
    assign error_count = r_err_count;

endmodule

// File: tb/tb_axis_user_check.sv
// Directed bench for axis_user_check: latency, wrap, errors, backpressure,
// saturation/clear interaction and mid-stream reset.
module tb_axis_user_check;
    localparam int DW = 8;
    localparam int UW = 8;
    localparam int EW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] s_tdata;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          clear;
    logic          locked;
    logic          error_flag;
    logic [EW-1:0] error_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] out_q[$];

    always #5 clock = ~clock;

    axis_user_check #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .ERROR_WIDTH(EW)) u_dut (
        .clock(clock), .reset(reset),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .clear(clear), .locked(locked), .error_flag(error_flag), .error_count(error_count)
    );

    always @(posedge clock)
        if (!reset && m_tvalid && m_tready) out_q.push_back(m_tdata);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [UW-1:0] u, input logic [DW-1:0] d);
        s_tvalid = 1'b1;
        s_tuser  = u;
        s_tdata  = d;
        tick();
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; s_tvalid = 1'b0; clear = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        out_q.delete();
    endtask

    task automatic chk_out(input string tag, input int n, input logic [DW-1:0] base);
        chk({tag, "_n"}, out_q.size(), n);
        for (int k = 0; k < n && k < out_q.size(); k++)
            chk({tag, "_d"}, out_q[k], base + DW'(k));
    endtask

    initial begin
        int i;
        logic w;
        reset = 1'b1; s_tvalid = 1'b0; s_tuser = '0; s_tdata = '0;
        m_tready = 1'b1; clear = 1'b0;

        tick(); tick();
        chk("rst_srdy", s_tready, 0);
        chk("rst_mvld", m_tvalid, 0);
        chk("rst_lock", locked, 0);
        chk("rst_flag", error_flag, 0);
        chk("rst_cnt", error_count, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_srdy", s_tready, 1);
        out_q.delete();

        // back-to-back 5..8: one-cycle latency and full throughput
        for (int k = 0; k < 4; k++) begin
            send(UW'(5 + k), DW'(8'hA0 + k));
            chk("lat_vld", m_tvalid, 1);
            chk("lat_data", m_tdata, 8'hA0 + k);
        end
        idle(); idle();
        chk_out("seq", 4, 8'hA0);
        chk("seq_lock", locked, 1);
        chk("seq_cnt", error_count, 0);

        // tag wrap 254,255,0,1
        do_reset();
        send(8'd254, 8'h01); send(8'd255, 8'h02); send(8'd0, 8'h03); send(8'd1, 8'h04);
        idle(); idle();
        chk("wrap_cnt", error_count, 0);
        chk("wrap_flag", error_flag, 0);
        chk_out("wrap", 4, 8'h01);

        // gap 10,11,14,15
        do_reset();
        send(8'd10, 8'h50); send(8'd11, 8'h51);
        chk("gap_cnt0", error_count, 0);
        send(8'd14, 8'h52);
        chk("gap_cnt1", error_count, 1);
        chk("gap_flag", error_flag, 1);
        send(8'd15, 8'h53);
        chk("gap_cnt15", error_count, 1);
        idle(); idle();
        chk_out("gap", 4, 8'h50);

        // backpressure: only two beats fit
        do_reset();
        m_tready = 1'b0;
        i = 0;
        for (int c = 0; c < 6; c++) begin
            s_tvalid = 1'b1; s_tuser = UW'(20 + i); s_tdata = DW'(8'h30 + i);
            w = s_tready;
            tick();
            if (w) i++;
            if (c >= 2) chk("bp_hold", m_tdata, 8'h30);
        end
        chk("bp_acc", i, 2);
        chk("bp_srdy", s_tready, 0);
        chk("bp_mvld", m_tvalid, 1);
        m_tready = 1'b1;
        for (int c = 0; c < 20 && i < 6; c++) begin
            s_tvalid = 1'b1; s_tuser = UW'(20 + i); s_tdata = DW'(8'h30 + i);
            w = s_tready;
            tick();
            if (w) i++;
        end
        chk("bp_total", i, 6);
        idle(); idle(); idle();
        chk_out("bp", 6, 8'h30);
        chk("bp_cnt", error_count, 0);

        // saturation and clear
        do_reset();
        send(8'd0, 8'h00);
        send(8'd50, 8'h01); chk("sat1", error_count, 1);
        send(8'd60, 8'h02); chk("sat2", error_count, 2);
        send(8'd70, 8'h03); chk("sat3", error_count, 3);
        send(8'd80, 8'h04); chk("sat4", error_count, 3);
        send(8'd90, 8'h05); chk("sat5", error_count, 3);
        chk("sat_flag", error_flag, 1);
        s_tvalid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_cnt", error_count, 0);
        chk("clr_flag", error_flag, 0);
        chk("clr_lock", locked, 1);
        clear = 1'b1;
        send(8'd200, 8'h06);
        chk("clr_err_cnt", error_count, 1);
        chk("clr_err_flag", error_flag, 1);
        send(8'd201, 8'h07);
        chk("clr_ok_cnt", error_count, 0);
        chk("clr_ok_flag", error_flag, 0);
        clear = 1'b0;
        send(8'd202, 8'h08);
        chk("resync_cnt", error_count, 0);
        idle();

        // reset with two beats buffered
        do_reset();
        m_tready = 1'b0;
        send(8'd1, 8'h11); send(8'd2, 8'h22);
        s_tvalid = 1'b0;
        chk("mid_full", m_tvalid, 1);
        reset = 1'b1;
        tick();
        chk("mid_mvld", m_tvalid, 0);
        chk("mid_lock", locked, 0);
        reset = 1'b0;
        tick();
        out_q.delete();
        m_tready = 1'b1;
        send(8'd100, 8'h64);
        chk("relock_vld", m_tvalid, 1);
        chk("relock_data", m_tdata, 8'h64);
        idle();
        chk("relock_lock", locked, 1);
        chk("relock_cnt", error_count, 0);
        chk("relock_flag", error_flag, 0);
        chk_out("relock", 1, 8'h64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
